pipe_mac_acc: RTL

Parametrised 4-stage pipelined multiply-add/accumulate datapath for the arithmetic pipeline family.
- Computes g = a*b + c + OFFSET per sample (direct mode), or g = acc + c + OFFSET with acc += a*b (accumulate mode).
- Adds valid tracking, selectable wrap/saturate arithmetic and a sticky overflow flag.
- Sits between input sample registers and downstream consumers, one sample per clock.

---
 rtl/pipe_mac_acc_pkg.sv | 8 +
 rtl/pipe_mac_acc_sat_add.sv | 19 +
 rtl/pipe_mac_acc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_mac_acc_pkg.sv
// Shared constants for the pipelined multiply-add/accumulate datapath.
package pipe_mac_acc_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_ACC    = 1'b1;
    localparam int   PIPE_LAT    = 4;

endpackage

// File: rtl/pipe_mac_acc_sat_add.sv
// Unsigned W-bit adder: wraps (SAT=0) or clamps to all-ones (SAT=1); ovf flags the carry out.
// Purely combinational, no latency, no flow control.
module sat_add #(
    parameter int W   = 16,
    parameter int SAT = 0
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {1'b0, x} + {1'b0, y};
    assign ovf  = full[W];
    assign sum  = ((SAT != 0) && full[W]) ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/pipe_mac_acc.sv
// 4-stage multiply-add / accumulate pipeline with sticky overflow flag.
// Latency 4 clocks, one sample per clock, no backpressure (pipeline always advances).
module pipe_mac_acc
    import pipe_mac_acc_pkg::*;
#(
    parameter int               IN_W   = 8,
    parameter int               OUT_W  = 16,
    parameter logic [OUT_W-1:0] OFFSET = 'h004E,
    parameter int               SAT    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             acc_clr,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [IN_W-1:0]  c,
    output logic             out_valid,
    output logic [OUT_W-1:0] g,
    output logic             ovf
);

    if (OUT_W < 2 * IN_W) begin : g_width_check
        $error("pipe_mac_acc: OUT_W must be >= 2*IN_W");
    end

    // Stage 1: input capture
    logic            v1, mode1, clr1;
    logic [IN_W-1:0] a1, b1, c1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1    <= 1'b0;
            mode1 <= 1'b0;
            clr1  <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            c1    <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                mode1 <= mode;
                clr1  <= acc_clr;
                a1    <= a;
                b1    <= b;
                c1    <= c;
            end
        end
    end

    // Stage 2: full-width product, which always fits in OUT_W
    logic [2*IN_W-1:0] prod_full;
    logic [OUT_W-1:0]  prod2;
    logic [IN_W-1:0]   c2;
    logic              v2, mode2, clr2;

    assign prod_full = a1 * b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            v2    <= 1'b0;
            mode2 <= 1'b0;
            clr2  <= 1'b0;
            prod2 <= '0;
            c2    <= '0;
        end else begin
            v2    <= v1;
            mode2 <= mode1;
            clr2  <= clr1;
            prod2 <= OUT_W'(prod_full);
            c2    <= c1;
        end
    end

    // Stage 3: accumulate and add c
    logic [OUT_W-1:0] acc, acc_base, acc_next, add_in, s3_next, s3;
    logic             acc_ovf, c_ovf, v3, ovf3, clr3;
    logic             is_acc;

    assign is_acc   = (mode2 == MODE_ACC);
    assign acc_base = clr2 ? '0 : acc;
    assign add_in   = is_acc ? acc_next : prod2;

    sat_add #(.W(OUT_W), .SAT(SAT)) u_add_acc (
        .x(acc_base), .y(prod2), .sum(acc_next), .ovf(acc_ovf)
    );

    sat_add #(.W(OUT_W), .SAT(SAT)) u_add_c (
        .x(add_in), .y(OUT_W'(c2)), .sum(s3_next), .ovf(c_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            v3   <= 1'b0;
            acc  <= '0;
            s3   <= '0;
            ovf3 <= 1'b0;
            clr3 <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                if (is_acc) begin
                    acc <= acc_next;
                end
                s3   <= s3_next;
                ovf3 <= c_ovf | (is_acc & acc_ovf);
                clr3 <= is_acc & clr2;
            end
        end
    end

    // Stage 4: offset and sticky flag; a clear and an overflow on the same sample leave ovf set
    logic [OUT_W-1:0] g_next;
    logic             off_ovf;

    sat_add #(.W(OUT_W), .SAT(SAT)) u_add_off (
        .x(s3), .y(OFFSET), .sum(g_next), .ovf(off_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            g         <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                g   <= g_next;
                ovf <= (ovf & ~clr3) | ovf3 | off_ovf;
            end
        end
    end

endmodule
